jpeg_stream_sequencer: RTL and testbench
========================================

Name: jpeg_stream_sequencer

Overview:
- Stream-level control for the JPEG pipeline, parametrised for multi-channel MCUs.
- Counts input-side and output-side blocks per channel and tracks the current component index.
- Every RESTART_INTERVAL MCUs: drains and flushes the Huffman coder and byte stuffer, resets them, and inserts an RSTn marker.
- At end of image: drains, flushes, emits EOI (FFD9). Sits between the byte stuffer output and the stream writer.

Parameters:
- NUM_CHANNELS, 3, blocks per MCU (1 = grey, 3 = YCbCr 4:4:4); range 1..4.
- RESTART_INTERVAL, 0, MCUs between restart markers; 0 disables restarts.
- RI_W, 16, width of the MCU counters.
- DRAIN_CYCLES, 4, wait cycles after the last done_block before the Huffman flush; must be >= 1.

Ports:
- clk  in  1  clock
- rst_ext  in  1  asynchronous active-high reset
- blk_in  in  1  pulse: one full block accepted into the pipeline front end
- done_block  in  1  pulse: run encoder finished a block
- done_image  in  1  pulse: last block of the image accepted
- hold_in  out  1  front end must stop accepting pixels
- channel  out  2  component index of the block currently leaving the run encoder
- flush_huff  out  1  Huffman coder flush request
- flush_stuff  out  1  byte stuffer flush request
- rst_pipeline  out  1  one-cycle reset of Huffman/stuffer bit state
- rst_dc  out  1  one-cycle DC-predictor reset
- stuff_bits  in  16  byte stuffer data
- stuff_valid  in  2  byte count 0..2
- stuff_ena  in  1  byte stuffer output valid
- stuff_rdy  in  1  byte stuffer ready (flush accepted)
- stuff_rdy_in  out  1  backpressure to the byte stuffer
- out_bits  out  16  output data, MSB byte first
- out_valid  out  2  output byte count
- ena_out  out  1  output valid
- rdy_in  in  1  downstream ready
- done_flush  out  1  one-cycle pulse: image fully emitted

Behaviour:
- Reset (asynchronous, rst_ext high) forces:
  - state BUSY;
  - all counters, channel and rst_idx cleared;
  - every output 0, except that the pass-through mux follows its inputs.
- Handshake: a transfer occurs when ena && rdy.
  - In every state except MARKER: out_bits, out_valid and ena_out equal the stuff_* inputs combinationally, and stuff_rdy_in = rdy_in.
- Input counters:
  - in_ch/in_mcu advance on blk_in; in_ch wraps at NUM_CHANNELS-1, incrementing in_mcu.
  - With restarts on: hold_in is set (registered) when the blk_in that completes MCU RESTART_INTERVAL-1 arrives. It is also set on done_image.
  - hold_in clears on return to BUSY after a marker.
- Output counters:
  - channel/out_mcu advance on done_block the same way.
  - Restart trigger: a done_block that completes MCU index RESTART_INTERVAL-1. It sets kind=RST and the state goes BUSY->DRAIN; out_mcu clears.
- done_image:
  - Sets a pending flag. When all blocks have drained (out block count equals in block count), kind=EOI and BUSY->DRAIN.
  - If the same done_block is both the restart trigger and the last block, EOI wins and no RST is emitted.
- State transitions:
  - DRAIN: waits DRAIN_CYCLES cycles, then goes to FLUSH_HUFF.
  - FLUSH_HUFF: flush_huff=1; exits to FLUSH_STUFF on stuff_rdy.
  - FLUSH_STUFF: flush_stuff=1; exits on rdy_in (minimum one cycle). On exit, rst_pipeline pulses for one cycle (registered) and the state goes to MARKER.
  - MARKER: out_bits={8'hFF, code}, out_valid=2, ena_out=1, stuff_rdy_in=0. Held until rdy_in. code = D0+rst_idx (RST) or D9 (EOI).
- Leaving MARKER:
  - On RST: rst_idx increments mod 8, rst_dc pulses one cycle, and the state returns to BUSY.
  - On EOI: done_flush pulses one cycle; all counters, rst_idx and the pending flag clear; the state returns to BUSY.
- Counting during the sequence: done_block and blk_in arriving outside BUSY are still counted but cannot trigger.
- done_image during a restart sequence stays pending and is serviced after the return to BUSY.

Optional Feature:
- JPEG_RESTART_EN defined: restart counting and RSTn insertion as above.
- Undefined: RESTART_INTERVAL is ignored, no RST trigger logic, rst_dc tied 0. hold_in asserts only for EOI; only EOI sequencing remains.

Decomposition:
- Shared package jpeg_pkg:
  - state enum (BUSY, DRAIN, FLUSH_HUFF, FLUSH_STUFF, MARKER);
  - marker codes MARKER_RST0=8'hD0, MARKER_EOI=8'hD9;
  - typedef for byte count (logic [1:0]).
- One natural sub-module, mcu_counter: the channel/MCU counter with wrap and terminal-count output, instantiated twice (input side, output side).

Test Plan:
- NUM_CHANNELS=1, RESTART_INTERVAL=0: 4 blk_in and 4 done_block, then done_image.
  - Expect DRAIN for 4 cycles, flush_huff until stuff_rdy, flush_stuff, then output FFD9 with out_valid=2.
  - Expect done_flush for exactly 1 cycle.
- NUM_CHANNELS=3, RESTART_INTERVAL=2: 12 blocks.
  - Expect hold_in after blk_in #6.
  - Expect FFD0 after done_block #6, rst_dc pulse, then hold_in released.
  - Expect FFD1 after block #12 unless done_image accompanies it, in which case only FFD9.
- RESTART_INTERVAL=1, 9 MCUs: expect markers D0..D7, then D0 (mod-8 wrap).
- Backpressure: hold rdy_in=0 for 5 cycles during MARKER.
  - Expect out_bits stable at FFD0, stuff_rdy_in=0, no state advance.
- Pass-through: stuff_bits=16'hAB00, stuff_valid=1 in BUSY.
  - Expect identical outputs the same cycle; stuff_rdy_in mirrors rdy_in.
- Assert rst_ext mid-FLUSH_HUFF.
  - Expect immediate BUSY, flush_huff=0, counters zero.
  - Expect the next image to start cleanly with the first marker FFD0.

Source files
------------

// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared states, marker codes and byte-count type for the JPEG stream sequencer.
package jpeg_pkg;
  typedef enum logic [2:0] {BUSY, DRAIN, FLUSH_HUFF, FLUSH_STUFF, MARKER} state_t;
  typedef enum logic {KIND_RST, KIND_EOI} kind_t;
  typedef logic [1:0] byte_cnt_t;
  localparam logic [7:0] MARKER_RST0 = 8'hD0;
  localparam logic [7:0] MARKER_EOI  = 8'hD9;
endpackage

// File: rtl/mcu_counter.sv
// mcu_counter: channel/MCU block counter; MCU index wraps after MCU_WRAP MCUs (0 = never) with tc on that block.
module mcu_counter #(
  parameter int NUM_CHANNELS = 3,
  parameter int MCU_WRAP     = 0,
  parameter int RI_W         = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  output logic [1:0]      ch,
  output logic [1:0]      ch_n,
  output logic [RI_W-1:0] mcu,
  output logic [RI_W-1:0] mcu_n,
  output logic            tc
);
  logic [1:0]      ch_q, ch_d;
  logic [RI_W-1:0] mcu_q, mcu_d;
  logic            wrap;
  always_comb begin
    wrap  = inc && ch_q == 2'(NUM_CHANNELS - 1);
    tc    = wrap && (MCU_WRAP != 0) && mcu_q == RI_W'(MCU_WRAP - 1);
    ch_d  = clr ? '0 : wrap ? '0 : inc ? ch_q + 2'd1 : ch_q;
    mcu_d = clr ? '0 : tc ? '0 : wrap ? mcu_q + 1'b1 : mcu_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ch_q  <= '0;
      mcu_q <= '0;
    end else begin
      ch_q  <= ch_d;
      mcu_q <= mcu_d;
    end
  assign ch    = ch_q;
  assign ch_n  = ch_d;
  assign mcu   = mcu_q;
  assign mcu_n = mcu_d;
endmodule

// File: rtl/jpeg_stream_sequencer.sv
// jpeg_stream_sequencer: drains/flushes the entropy back end and inserts EOI (and RSTn markers when
// JPEG_RESTART_EN is defined) between the byte stuffer and the stream writer.
module jpeg_stream_sequencer
  import jpeg_pkg::*;
#(
  parameter int NUM_CHANNELS     = 3,
  parameter int RESTART_INTERVAL = 0,
  parameter int RI_W             = 16,
  parameter int DRAIN_CYCLES     = 4
) (
  input  logic      clk,
  input  logic      rst_ext,
  input  logic      blk_in,
  input  logic      done_block,
  input  logic      done_image,
  output logic      hold_in,
  output logic [1:0] channel,
  output logic      flush_huff,
  output logic      flush_stuff,
  output logic      rst_pipeline,
  output logic      rst_dc,
  input  logic [15:0] stuff_bits,
  input  byte_cnt_t stuff_valid,
  input  logic      stuff_ena,
  input  logic      stuff_rdy,
  output logic      stuff_rdy_in,
  output logic [15:0] out_bits,
  output byte_cnt_t out_valid,
  output logic      ena_out,
  input  logic      rdy_in,
  output logic      done_flush
);
`ifdef JPEG_RESTART_EN
  localparam int MCU_WRAP = RESTART_INTERVAL;
`else
  localparam int MCU_WRAP = RESTART_INTERVAL * 0;
`endif
  state_t          state_q, state_d;
  kind_t           kind_q, kind_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      rst_idx_q, rst_idx_d;
  logic            pend_q, pend_d, hold_q, hold_d;
  logic            rst_pipeline_q, rst_pipeline_d, rst_dc_q, rst_dc_d, done_flush_q, done_flush_d;
  logic [1:0]      in_ch, in_ch_n, out_ch_n;
  logic [RI_W-1:0] in_mcu, in_mcu_n, out_mcu, out_mcu_n;
  logic            in_tc, out_tc, eoi_clr, mk, drained, last_blk, rst_trig;
  logic [7:0]      code;
  mcu_counter #(.NUM_CHANNELS(NUM_CHANNELS), .MCU_WRAP(MCU_WRAP), .RI_W(RI_W)) u_in (
    .clk(clk), .rst(rst_ext), .clr(eoi_clr), .inc(blk_in),
    .ch(in_ch), .ch_n(in_ch_n), .mcu(in_mcu), .mcu_n(in_mcu_n), .tc(in_tc)
  );
  mcu_counter #(.NUM_CHANNELS(NUM_CHANNELS), .MCU_WRAP(MCU_WRAP), .RI_W(RI_W)) u_out (
    .clk(clk), .rst(rst_ext), .clr(eoi_clr), .inc(done_block),
    .ch(channel), .ch_n(out_ch_n), .mcu(out_mcu), .mcu_n(out_mcu_n), .tc(out_tc)
  );
  assign eoi_clr      = state_q == MARKER && rdy_in && kind_q == KIND_EOI;
  assign mk           = state_q == MARKER;
  assign code         = kind_q == KIND_EOI ? MARKER_EOI : MARKER_RST0 + {5'd0, rst_idx_q};
  assign out_bits     = mk ? {8'hFF, code} : stuff_bits;
  assign out_valid    = mk ? 2'd2 : stuff_valid;
  assign ena_out      = mk | stuff_ena;
  assign stuff_rdy_in = !mk && rdy_in;
  assign flush_huff   = state_q == FLUSH_HUFF;
  assign flush_stuff  = state_q == FLUSH_STUFF;
  assign hold_in      = hold_q;
  assign rst_pipeline = rst_pipeline_q;
  assign rst_dc       = rst_dc_q;
  assign done_flush   = done_flush_q;
  // A restart trigger that is also the image's last block yields to EOI.
  assign drained  = {in_mcu, in_ch} == {out_mcu, channel};
  assign last_blk = (pend_q | done_image) && {in_mcu_n, in_ch_n} == {out_mcu_n, out_ch_n};
  assign rst_trig = out_tc && !last_blk;
  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    cnt_d          = state_q == DRAIN ? cnt_q + 16'd1 : '0;
    rst_idx_d      = rst_idx_q;
    pend_d         = pend_q | done_image;
    hold_d         = hold_q | done_image | in_tc;
    rst_pipeline_d = 1'b0;
    rst_dc_d       = 1'b0;
    done_flush_d   = 1'b0;
    case (state_q)
      BUSY:
        if (pend_q && drained) begin
          kind_d  = KIND_EOI;
          state_d = DRAIN;
        end else if (rst_trig) begin
          kind_d  = KIND_RST;
          state_d = DRAIN;
        end
      DRAIN:       state_d = cnt_q == 16'(DRAIN_CYCLES - 1) ? FLUSH_HUFF : DRAIN;
      FLUSH_HUFF:  state_d = stuff_rdy ? FLUSH_STUFF : FLUSH_HUFF;
      FLUSH_STUFF:
        if (rdy_in) begin
          state_d        = MARKER;
          rst_pipeline_d = 1'b1;
        end
      MARKER:
        if (rdy_in) begin
          state_d = BUSY;
          if (kind_q == KIND_EOI) begin
            done_flush_d = 1'b1;
            pend_d       = 1'b0;
            hold_d       = 1'b0;
            rst_idx_d    = '0;
          end else begin
            rst_idx_d = rst_idx_q + 3'd1;
            hold_d    = pend_q | done_image | in_tc;
`ifdef JPEG_RESTART_EN
            rst_dc_d  = 1'b1;
`endif
          end
        end
      default: state_d = BUSY;
    endcase
  end
  always_ff @(posedge clk or posedge rst_ext)
    if (rst_ext) begin
      state_q        <= BUSY;
      kind_q         <= KIND_RST;
      cnt_q          <= '0;
      rst_idx_q      <= '0;
      pend_q         <= 1'b0;
      hold_q         <= 1'b0;
      rst_pipeline_q <= 1'b0;
      rst_dc_q       <= 1'b0;
      done_flush_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      kind_q         <= kind_d;
      cnt_q          <= cnt_d;
      rst_idx_q      <= rst_idx_d;
      pend_q         <= pend_d;
      hold_q         <= hold_d;
      rst_pipeline_q <= rst_pipeline_d;
      rst_dc_q       <= rst_dc_d;
      done_flush_q   <= done_flush_d;
    end
endmodule

// File: tb/tb_jpeg_stream_sequencer.sv
// tb_jpeg_stream_sequencer: directed self-checking bench for jpeg_stream_sequencer (3 channels, interval 2).
module tb_jpeg_stream_sequencer;
  logic clk = 1'b0, rst_ext = 1'b1;
  logic blk_in = 1'b0, done_block = 1'b0, done_image = 1'b0;
  logic hold_in, flush_huff, flush_stuff, rst_pipeline, rst_dc, done_flush;
  logic [1:0] channel;
  logic [15:0] stuff_bits = '0, out_bits;
  logic [1:0] stuff_valid = '0, out_valid;
  logic stuff_ena = 1'b0, stuff_rdy = 1'b0, stuff_rdy_in, ena_out, rdy_in = 1'b1;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  jpeg_stream_sequencer #(.NUM_CHANNELS(3), .RESTART_INTERVAL(2), .RI_W(16), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .rst_ext(rst_ext), .blk_in(blk_in), .done_block(done_block), .done_image(done_image),
    .hold_in(hold_in), .channel(channel), .flush_huff(flush_huff), .flush_stuff(flush_stuff),
    .rst_pipeline(rst_pipeline), .rst_dc(rst_dc), .stuff_bits(stuff_bits), .stuff_valid(stuff_valid),
    .stuff_ena(stuff_ena), .stuff_rdy(stuff_rdy), .stuff_rdy_in(stuff_rdy_in), .out_bits(out_bits),
    .out_valid(out_valid), .ena_out(ena_out), .rdy_in(rdy_in), .done_flush(done_flush)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic blk(input int n);
    repeat (n) begin
      @(posedge clk) #1 blk_in = 1'b1;
      @(posedge clk) #1 blk_in = 1'b0;
    end
  endtask
  task automatic done(input int n);
    repeat (n) begin
      @(posedge clk) #1 done_block = 1'b1;
      @(posedge clk) #1 done_block = 1'b0;
    end
  endtask
  task automatic end_image;
    @(posedge clk) #1 done_image = 1'b1;
    @(posedge clk) #1 done_image = 1'b0;
  endtask
  task automatic wait_flush(output int n);
    n = 0;
    @(negedge clk);
    while (!flush_huff && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("flush_huff_reached", flush_huff, 1);
  endtask
  task automatic seq(input logic [7:0] code, input logic dc);
    int n;
    wait_flush(n);
    @(posedge clk) #1 stuff_rdy = 1'b1;
    @(posedge clk) #1 stuff_rdy = 1'b0;
    @(negedge clk) check("seq_flush_stuff", flush_stuff, 1);
    @(negedge clk);
    check("seq_marker_bits", out_bits, {8'hFF, code});
    check("seq_marker_valid", out_valid, 2);
    check("seq_marker_rdy", stuff_rdy_in, 0);
    check("seq_rst_pipeline", rst_pipeline, 1);
    @(negedge clk);
    check("seq_rst_dc", rst_dc, dc);
    check("seq_done_flush", done_flush, !dc);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, hits;
    logic [1:0] exp_ch [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
    repeat (2) @(posedge clk);
    #1 rst_ext = 1'b0;
    @(negedge clk);
    check("rst_hold", hold_in, 0);
    check("rst_channel", channel, 0);
    check("rst_flush_huff", flush_huff, 0);
    check("rst_flush_stuff", flush_stuff, 0);
    check("rst_pipeline", rst_pipeline, 0);
    check("rst_dc", rst_dc, 0);
    check("rst_done_flush", done_flush, 0);
    stuff_bits = 16'hAB00; stuff_valid = 2'd1; stuff_ena = 1'b1;
    #1;
    check("pass_bits", out_bits, 16'hAB00);
    check("pass_valid", out_valid, 1);
    check("pass_ena", ena_out, 1);
    check("pass_rdy1", stuff_rdy_in, 1);
    rdy_in = 1'b0;
    #1 check("pass_rdy0", stuff_rdy_in, 0);
    rdy_in = 1'b1; stuff_ena = 1'b0;
    blk(4);
    @(negedge clk) check("chan_in_only", channel, 0);
    for (int i = 0; i < 4; i++) begin
      done(1);
      @(negedge clk) check("chan_count", channel, exp_ch[i]);
    end
    check("hold_idle", hold_in, 0);
    end_image;
    n = 0;
    @(negedge clk);
    check("hold_eoi", hold_in, 1);
    while (!flush_huff && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("drain_len", n, 5);
    check("huff_no_stuff", flush_stuff, 0);
    repeat (2) @(negedge clk) check("huff_hold", flush_huff, 1);
    @(posedge clk) #1 begin stuff_rdy = 1'b1; rdy_in = 1'b0; end
    @(posedge clk) #1 stuff_rdy = 1'b0;
    @(negedge clk);
    check("stuff_on", flush_stuff, 1);
    check("huff_off", flush_huff, 0);
    @(negedge clk) check("stuff_wait", flush_stuff, 1);
    @(posedge clk) #1 rdy_in = 1'b1;
    @(posedge clk) #1 rdy_in = 1'b0;
    @(negedge clk);
    check("eoi_bits", out_bits, 16'hFFD9);
    check("eoi_valid", out_valid, 2);
    check("eoi_ena", ena_out, 1);
    check("eoi_rst_pipeline", rst_pipeline, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_bits", out_bits, 16'hFFD9);
      check("bp_rst_pipeline", rst_pipeline, 0);
      check("bp_done_flush", done_flush, 0);
    end
    @(posedge clk) #1 rdy_in = 1'b1;
    @(negedge clk);
    check("eoi_rdy_blocked", stuff_rdy_in, 0);
    check("eoi_bits_xfer", out_bits, 16'hFFD9);
    @(negedge clk);
    check("eoi_done_flush", done_flush, 1);
    check("eoi_hold_clear", hold_in, 0);
    check("eoi_chan_clear", channel, 0);
    check("eoi_pass_back", out_bits, 16'hAB00);
    hits = 0;
    repeat (4) @(negedge clk) hits += int'(done_flush);
    check("done_flush_extra", hits, 0);
`ifdef JPEG_RESTART_EN
    blk(5);
    @(negedge clk) check("hold_before6", hold_in, 0);
    blk(1);
    @(negedge clk) check("hold_after6", hold_in, 1);
    done(6);
    seq(8'hD0, 1'b1);
    check("hold_released", hold_in, 0);
    blk(6);
    done(5);
    @(posedge clk) #1 begin done_block = 1'b1; done_image = 1'b1; end
    @(posedge clk) #1 begin done_block = 1'b0; done_image = 1'b0; end
    seq(8'hD9, 1'b0);
    for (int i = 0; i < 9; i++) begin
      blk(6);
      done(6);
      seq(8'(8'hD0 + (i % 8)), 1'b1);
    end
    end_image;
    seq(8'hD9, 1'b0);
`else
    blk(6);
    @(negedge clk) check("hold_no_restart", hold_in, 0);
    done(5);
    @(negedge clk) check("chan_wrap", channel, 2);
    done(1);
    hits = 0;
    repeat (10) @(negedge clk) hits += int'(flush_huff);
    check("no_rst_flush", hits, 0);
    end_image;
    seq(8'hD9, 1'b0);
`endif
    blk(4);
    done(4);
    end_image;
    wait_flush(n);
    #2 rst_ext = 1'b1;
    #1;
    check("arst_flush_huff", flush_huff, 0);
    check("arst_hold", hold_in, 0);
    check("arst_channel", channel, 0);
    @(posedge clk) #1 rst_ext = 1'b0;
`ifdef JPEG_RESTART_EN
    blk(6);
    done(6);
    seq(8'hD0, 1'b1);
`else
    blk(2);
    done(2);
    @(negedge clk) check("arst_chan_fresh", channel, 2);
`endif
    end_image;
    seq(8'hD9, 1'b0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
